// File: rtl/ebus_arbiter.sv
// Two-master arbiter for the Z80 expansion bus: requests the bus with BUSREQ, waits for a
// synchronized BUSACK, grants one master round-robin and performs a driver turnaround on release.
module ebus_arbiter #(
   parameter int TIMEOUT    = 4095,
   parameter int TURNAROUND = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic req0,
   input  logic req1,
   input  logic ebus_busack_n,
   output logic busreq,
   output logic drive_en,
   output logic gnt0,
   output logic gnt1,
   output logic timeout_pulse,
   output logic ack_lost
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_ACK,
      S_GRANT,
      S_RELEASE,
      S_BACKOFF
   } state_t;

   localparam logic [11:0] LP_TIMEOUT      = 12'(TIMEOUT);
   localparam logic [11:0] LP_TURN_LAST    = 12'(TURNAROUND - 1);
   localparam logic [11:0] LP_BACKOFF_LAST = 12'd15;

   state_t      r_state;
   logic [11:0] r_cnt;
   logic        r_owner;
   logic        r_last;
   logic        r_sync1;
   logic        r_sync2;
   logic        r_busreq;
   logic        r_gnt0;
   logic        r_gnt1;
   logic        r_timeout;
   logic        r_ack_lost;

   logic        w_ack_s;
   logic        w_owner_req;
   logic        w_winner;

   // NOTE: non-blocking assignments make both stages sample their pre-edge inputs; a blocking
   // chain here would collapse the synchronizer into a single flop.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= ebus_busack_n;
         r_sync2 <= r_sync1;
      end
   end

   assign w_ack_s     = ~r_sync2;
   assign w_owner_req = r_owner ? req1 : req0;
   // r_last holds the requester served last; the other one wins a tie.
   assign w_winner    = req1 & (~req0 | ~r_last);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_owner    <= 1'b0;
         r_last     <= 1'b1;
         r_busreq   <= 1'b0;
         r_gnt0     <= 1'b0;
         r_gnt1     <= 1'b0;
         r_timeout  <= 1'b0;
         r_ack_lost <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req0 | req1) begin
                  r_owner  <= w_winner;
                  r_busreq <= 1'b1;
                  r_cnt    <= '0;
                  r_state  <= S_WAIT_ACK;
               end
            end
            S_WAIT_ACK: begin
               if (!w_owner_req) begin
                  r_busreq <= 1'b0;
                  r_cnt    <= '0;
                  r_state  <= S_IDLE;
               end else if (w_ack_s) begin
                  r_gnt0  <= ~r_owner;
                  r_gnt1  <= r_owner;
                  r_last  <= r_owner;
                  r_cnt   <= '0;
                  r_state <= S_GRANT;
               end else if (r_cnt == LP_TIMEOUT) begin
                  r_timeout <= 1'b1;
                  r_busreq  <= 1'b0;
                  r_last    <= r_owner;
                  r_cnt     <= '0;
                  r_state   <= S_BACKOFF;
               end else begin
                  r_cnt <= r_cnt + 12'd1;
               end
            end
            S_GRANT: begin
               if (!w_owner_req || !w_ack_s) begin
                  // Leaving while the owner still requests can only mean the acknowledge vanished.
                  r_ack_lost <= r_ack_lost | w_owner_req;
                  r_gnt0     <= 1'b0;
                  r_gnt1     <= 1'b0;
                  r_cnt      <= '0;
                  r_state    <= S_RELEASE;
               end
            end
            S_RELEASE: begin
               if (r_cnt == LP_TURN_LAST) begin
                  r_busreq <= 1'b0;
                  r_cnt    <= '0;
                  r_state  <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 12'd1;
               end
            end
            S_BACKOFF: begin
               if (r_cnt == LP_BACKOFF_LAST) begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 12'd1;
               end
            end
            default: begin
               r_cnt   <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busreq        = r_busreq;
   assign gnt0          = r_gnt0;
   assign gnt1          = r_gnt1;
   assign drive_en      = r_gnt0 | r_gnt1;
   assign timeout_pulse = r_timeout;
   assign ack_lost      = r_ack_lost;

endmodule

// File: tb/tb_ebus_arbiter.sv
// Bench for ebus_arbiter: a procedural timeline model of the bus protocol checked every cycle,
// directed scenarios with hand-computed cycle expectations, then randomized traffic.
module tb_ebus_arbiter;

   localparam int TIMEOUT    = 15;
   localparam int TURNAROUND = 2;

   logic clk;
   logic reset;
   logic req0;
   logic req1;
   logic ebus_busack_n;
   logic busreq;
   logic drive_en;
   logic gnt0;
   logic gnt1;
   logic timeout_pulse;
   logic ack_lost;

   int n_cmp  = 0;
   int n_fail = 0;

   ebus_arbiter #(
      .TIMEOUT   (TIMEOUT),
      .TURNAROUND(TURNAROUND)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req0         (req0),
      .req1         (req1),
      .ebus_busack_n(ebus_busack_n),
      .busreq       (busreq),
      .drive_en     (drive_en),
      .gnt0         (gnt0),
      .gnt1         (gnt1),
      .timeout_pulse(timeout_pulse),
      .ack_lost     (ack_lost)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: the protocol as a timeline of edges ----------------
   logic [1:0] m_pin;
   logic       m_req0, m_req1, m_ack, m_rst;
   logic       e_busreq, e_gnt0, e_gnt1, e_tmo, e_lost;
   int         m_last;
   bit         m_ready;

   // Advance one rising edge, sampling what the arbiter sees at that edge.
   task automatic tick();
      @(posedge clk);
      m_req0 = req0;
      m_req1 = req1;
      m_ack  = ~m_pin[1];
      m_pin  = {m_pin[0], ebus_busack_n};
      m_rst  = reset;
      e_tmo  = 1'b0;
      if (reset) begin
         m_pin    = 2'b11;
         e_busreq = 1'b0;
         e_gnt0   = 1'b0;
         e_gnt1   = 1'b0;
         e_lost   = 1'b0;
         m_last   = 1;
         m_ready  = 1'b1;
      end
   endtask

   function automatic logic owner_req(input int owner);
      return (owner == 1) ? m_req1 : m_req0;
   endfunction

   initial begin : model
      int owner;
      int waited;
      int outcome;
      m_pin = 2'b11; m_last = 1; m_ready = 1'b0;
      e_busreq = 1'b0; e_gnt0 = 1'b0; e_gnt1 = 1'b0; e_tmo = 1'b0; e_lost = 1'b0;
      forever begin
         tick();
         if (m_rst || !(m_req0 || m_req1)) continue;
         if (m_req0 && m_req1) owner = 1 - m_last;
         else owner = m_req1 ? 1 : 0;
         e_busreq = 1'b1;
         waited  = 0;
         outcome = 0;
         forever begin
            tick();
            if (m_rst) break;
            if (!owner_req(owner)) begin e_busreq = 1'b0; break; end
            if (m_ack) begin
               outcome = 1; m_last = owner;
               e_gnt0 = (owner == 0); e_gnt1 = (owner == 1);
               break;
            end
            if (waited == TIMEOUT) begin
               outcome = 2; m_last = owner; e_tmo = 1'b1; e_busreq = 1'b0;
               break;
            end
            waited++;
         end
         if (m_rst) continue;
         if (outcome == 1) begin
            forever begin
               tick();
               if (m_rst) break;
               if (!owner_req(owner) || !m_ack) begin
                  if (owner_req(owner)) e_lost = 1'b1;
                  e_gnt0 = 1'b0; e_gnt1 = 1'b0;
                  break;
               end
            end
            if (m_rst) continue;
            for (int i = 1; i <= TURNAROUND; i++) begin
               tick();
               if (m_rst) break;
               if (i == TURNAROUND) e_busreq = 1'b0;
            end
         end else if (outcome == 2) begin
            for (int i = 0; i < 16; i++) begin
               tick();
               if (m_rst) break;
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (m_ready) begin
         check("busreq", busreq, e_busreq);
         check("gnt0", gnt0, e_gnt0);
         check("gnt1", gnt1, e_gnt1);
         check("drive_en", drive_en, e_gnt0 | e_gnt1);
         check("timeout_pulse", timeout_pulse, e_tmo);
         check("ack_lost", ack_lost, e_lost);
         check("gnt_onehot", gnt0 & gnt1, 1'b0);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_until(input string name, input bit on_grant, input logic val, input int lim);
      int n = 0;
      while (((on_grant ? (gnt0 | gnt1) : busreq) !== val) && n < lim) begin
         step(1);
         n++;
      end
      check(name, on_grant ? (gnt0 | gnt1) : busreq, val);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busreq"}, busreq, 1'b0);
      check({tag, "_drive_en"}, drive_en, 1'b0);
      check({tag, "_gnt0"}, gnt0, 1'b0);
      check({tag, "_gnt1"}, gnt1, 1'b0);
      check({tag, "_timeout"}, timeout_pulse, 1'b0);
      check({tag, "_ack_lost"}, ack_lost, 1'b0);
   endtask

   logic rr_exp [3] = '{1'b0, 1'b1, 1'b0};

   initial begin : stim
      logic got;
      int   hi, lo, pulses, bad, ack_dly;
      reset = 1'b1; req0 = 1'b0; req1 = 1'b0; ebus_busack_n = 1'b1;
      step(3);
      check_all_zero("reset");
      reset = 1'b0;
      step(2);

      // Single transaction timing from requester 0.
      req0 = 1'b1;
      step(1);
      check("t1_busreq_rise", busreq, 1'b1);
      check("t1_no_grant_yet", gnt0, 1'b0);
      step(4);
      ebus_busack_n = 1'b0;
      step(2);
      check("t1_grant_not_before_sync", gnt0, 1'b0);
      step(1);
      check("t1_gnt0_at_ack_plus3", gnt0, 1'b1);
      check("t1_drive_en_at_ack_plus3", drive_en, 1'b1);
      step(4);
      req0 = 1'b0;
      step(1);
      check("t1_drive_en_drop", drive_en, 1'b0);
      check("t1_turnaround_busreq1", busreq, 1'b1);
      step(1);
      check("t1_turnaround_busreq2", busreq, 1'b1);
      step(1);
      check("t1_busreq_drop", busreq, 1'b0);
      ebus_busack_n = 1'b1;
      step(4);

      // Round robin with both requesters permanently asking, from reset.
      reset = 1'b1; step(2); reset = 1'b0;
      req0 = 1'b1; req1 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_until("rr_busreq", 1'b0, 1'b1, 10);
         ebus_busack_n = 1'b0;
         wait_until("rr_grant", 1'b1, 1'b1, 10);
         got = gnt1;
         check("rr_winner", got, rr_exp[k]);
         step(3);
         if (got) req1 = 1'b0; else req0 = 1'b0;
         ebus_busack_n = 1'b1;
         wait_until("rr_release", 1'b0, 1'b0, 10);
         if (got) req1 = 1'b1; else req0 = 1'b1;
      end
      req0 = 1'b0; req1 = 1'b0;
      step(4);

      // Acknowledge never arrives: 16 waiting cycles, one pulse, 16 backoff + 1 arbitration cycle low.
      req1 = 1'b1;
      wait_until("tmo_busreq", 1'b0, 1'b1, 5);
      hi = 0;
      while (busreq === 1'b1 && hi < 40) begin hi++; step(1); end
      check("tmo_wait_cycles", hi, 16);
      check("tmo_pulse_with_drop", timeout_pulse, 1'b1);
      lo = 0; pulses = 0;
      while (busreq !== 1'b1 && lo < 40) begin
         pulses += int'(timeout_pulse);
         lo++;
         step(1);
      end
      check("tmo_low_cycles", lo, 17);
      check("tmo_pulse_count", pulses, 1);
      req1 = 1'b0;
      step(4);

      // Acknowledge lost while requester 1 owns the bus.
      req1 = 1'b1;
      wait_until("lost_busreq", 1'b0, 1'b1, 5);
      ebus_busack_n = 1'b0;
      wait_until("lost_grant", 1'b1, 1'b1, 10);
      check("lost_gnt1", gnt1, 1'b1);
      step(2);
      ebus_busack_n = 1'b1;
      step(2);
      check("lost_gnt1_held", gnt1, 1'b1);
      step(1);
      check("lost_flag", ack_lost, 1'b1);
      check("lost_gnt1_drop", gnt1, 1'b0);
      check("lost_drive_en_drop", drive_en, 1'b0);
      check("lost_turnaround1", busreq, 1'b1);
      step(1);
      check("lost_turnaround2", busreq, 1'b1);
      step(1);
      check("lost_busreq_drop", busreq, 1'b0);
      req1 = 1'b0;
      step(5);
      check("lost_sticky", ack_lost, 1'b1);

      // Reset while granted, then a normal transaction.
      req0 = 1'b1;
      wait_until("rg_busreq", 1'b0, 1'b1, 5);
      ebus_busack_n = 1'b0;
      wait_until("rg_grant", 1'b1, 1'b1, 10);
      step(2);
      reset = 1'b1;
      step(1);
      check_all_zero("rg_reset");
      reset = 1'b0;
      wait_until("rg_regrant", 1'b1, 1'b1, 10);
      check("rg_gnt0", gnt0, 1'b1);
      req0 = 1'b0;
      ebus_busack_n = 1'b1;
      wait_until("rg_release", 1'b0, 1'b0, 10);
      step(4);

      // Short request with no acknowledge: abandoned without grant or timeout.
      req0 = 1'b1;
      step(3);
      check("short_busreq", busreq, 1'b1);
      req0 = 1'b0;
      step(1);
      check("short_busreq_drop", busreq, 1'b0);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         bad += int'(gnt0 | gnt1 | timeout_pulse);
         step(1);
      end
      check("short_no_grant_no_pulse", bad, 0);

      // Randomized traffic against a bus master that answers with random latency.
      reset = 1'b1; step(2); reset = 1'b0;
      ack_dly = 3;
      for (int c = 0; c < 4000; c++) begin
         step(1);
         reset = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 9) == 0) req0 = ~req0;
         if ($urandom_range(0, 9) == 0) req1 = ~req1;
         if (busreq !== 1'b1) begin
            ebus_busack_n = 1'b1;
            ack_dly = ($urandom_range(0, 4) != 0) ? int'($urandom_range(1, 8)) : 30;
         end else if (ebus_busack_n == 1'b0) begin
            if ($urandom_range(0, 99) == 0) ebus_busack_n = 1'b1;
         end else if (ack_dly > 0) begin
            ack_dly--;
         end else begin
            ebus_busack_n = 1'b0;
         end
      end
      req0 = 1'b0; req1 = 1'b0; reset = 1'b0;
      step(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

endmodule
